// File: rtl/cp0_pkg.sv
// Shared CP0-side definitions: sequencer state encoding, handler address,
// exception codes and CP0 register indices.
package cp0_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } seq_state_t;

  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

endpackage

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET return sequencer at the M-stage / CP0 boundary.
// Flushes the pipe for FLUSH_CYCLES, then pulses a single PC redirect.
module exc_sequencer
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = HANDLER_PC_DEF,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_valid,
  input  logic [31:0]      m_pc,
  input  logic             m_bd,
  input  logic [4:0]       m_exc_code,
  input  logic             m_eret,
  input  logic [31:0]      e_pc,
  input  logic             e_bd,
  input  logic [5:0]       dev_int,
  input  logic             cp0_req,
  input  logic [31:0]      cp0_epc,
  output logic [4:0]       cp0_exc_code,
  output logic [31:0]      cp0_pc,
  output logic             cp0_bd,
  output logic [5:0]       cp0_hwint,
  output logic             cp0_exl_clr,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             busy,
  output logic [CNT_W-1:0] entry_count
);

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam seq_state_t ST_AFTER_TRIGGER = (FLUSH_CYCLES == 1) ? REDIRECT : FLUSH;

  seq_state_t       r_state;
  logic [2:0]       r_cnt;
  logic [31:0]      r_target;
  logic [CNT_W-1:0] r_entry_count;

  logic       w_run;
  logic       w_eret_go;
  logic [2:0] w_cnt_dec;

  assign w_run     = (r_state == RUN);
  assign w_eret_go = w_run & m_valid & m_eret & ~cp0_req;
  assign w_cnt_dec = r_cnt - 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_target      <= '0;
      r_entry_count <= '0;
    end else begin
      case (r_state)
        RUN: begin
          // Req has priority over ERET; CP0 has already committed the entry.
          if (cp0_req) begin
            r_target <= HANDLER_PC;
            r_cnt    <= CNT_LOAD;
            r_state  <= ST_AFTER_TRIGGER;
            if (r_entry_count != '1) r_entry_count <= r_entry_count + CNT_W'(1);
          end else if (m_valid && m_eret) begin
            r_target <= cp0_epc;
            r_cnt    <= CNT_LOAD;
            r_state  <= ST_AFTER_TRIGGER;
          end
        end
        FLUSH: begin
          r_cnt <= w_cnt_dec;
          if (w_cnt_dec == 3'd0) r_state <= REDIRECT;
        end
        REDIRECT: r_state <= RUN;
        default:  r_state <= RUN;
      endcase
    end
  end

  // CP0 sees live M/E-stage data only in RUN so nothing re-triggers mid-sequence.
  always_comb begin
    cp0_exc_code = '0;
    cp0_pc       = '0;
    cp0_bd       = 1'b0;
    cp0_hwint    = '0;
    cp0_exl_clr  = 1'b0;
    if (w_run) begin
      cp0_exc_code = m_valid ? m_exc_code : 5'd0;
      cp0_pc       = m_valid ? m_pc : e_pc;
      cp0_bd       = m_valid ? m_bd : e_bd;
      cp0_hwint    = dev_int;
      cp0_exl_clr  = w_eret_go;
    end
  end

  assign flush          = ~w_run | cp0_req | (m_valid & m_eret);
  assign busy           = ~w_run;
  assign redirect_valid = (r_state == REDIRECT);
  assign redirect_pc    = r_target;
  assign entry_count    = r_entry_count;

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: two instances (FLUSH_CYCLES 2 / CNT_W 16 and
// FLUSH_CYCLES 3 / CNT_W 2) against a cycle-count reference model plus directed cases.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid, m_bd, m_eret, e_bd, cp0_req;
  logic [31:0] m_pc, e_pc, cp0_epc;
  logic [4:0]  m_exc_code;
  logic [5:0]  dev_int;

  logic [4:0]  o_exc [2];
  logic [31:0] o_pc [2];
  logic        o_bd [2];
  logic [5:0]  o_hw [2];
  logic        o_exl [2];
  logic        o_flush [2];
  logic        o_rv [2];
  logic [31:0] o_rpc [2];
  logic        o_busy [2];
  logic [15:0] o_ec0;
  logic [1:0]  o_ec1;

  int nvec = 0;
  int nerr = 0;
  bit model_on = 0;

  always #5 clk = ~clk;

  exc_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc_code(m_exc_code), .m_eret(m_eret), .e_pc(e_pc), .e_bd(e_bd),
    .dev_int(dev_int), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_exc_code(o_exc[0]), .cp0_pc(o_pc[0]), .cp0_bd(o_bd[0]), .cp0_hwint(o_hw[0]),
    .cp0_exl_clr(o_exl[0]), .flush(o_flush[0]), .redirect_valid(o_rv[0]),
    .redirect_pc(o_rpc[0]), .busy(o_busy[0]), .entry_count(o_ec0));

  exc_sequencer #(.FLUSH_CYCLES(3), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc), .m_bd(m_bd),
    .m_exc_code(m_exc_code), .m_eret(m_eret), .e_pc(e_pc), .e_bd(e_bd),
    .dev_int(dev_int), .cp0_req(cp0_req), .cp0_epc(cp0_epc),
    .cp0_exc_code(o_exc[1]), .cp0_pc(o_pc[1]), .cp0_bd(o_bd[1]), .cp0_hwint(o_hw[1]),
    .cp0_exl_clr(o_exl[1]), .flush(o_flush[1]), .redirect_valid(o_rv[1]),
    .redirect_pc(o_rpc[1]), .busy(o_busy[1]), .entry_count(o_ec1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a sequence is "k cycles since trigger"; redirect when k == FC.
  int          fc   [2] = '{2, 3};
  int          cmax [2] = '{65535, 3};
  bit          md_in  [2];
  int          md_k   [2];
  logic [31:0] md_tgt [2];
  int          md_cnt [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      md_in[i] = 0; md_k[i] = 0; md_tgt[i] = 0; md_cnt[i] = 0;
    end
  end

  function automatic logic [31:0] ec_of(input int i);
    return (i == 0) ? {16'd0, o_ec0} : {30'd0, o_ec1};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (model_on) begin
        check("busy", {31'd0, o_busy[i]}, {31'd0, md_in[i]});
        check("flush", {31'd0, o_flush[i]},
              {31'd0, md_in[i] || cp0_req || (m_valid && m_eret)});
        check("exl_clr", {31'd0, o_exl[i]},
              {31'd0, !md_in[i] && m_valid && m_eret && !cp0_req});
        check("redirect_valid", {31'd0, o_rv[i]}, {31'd0, md_in[i] && md_k[i] == fc[i]});
        check("exc_code", {27'd0, o_exc[i]},
              (md_in[i] || !m_valid) ? 32'd0 : {27'd0, m_exc_code});
        check("hwint", {26'd0, o_hw[i]}, md_in[i] ? 32'd0 : {26'd0, dev_int});
        if (!md_in[i]) begin
          check("cp0_pc", o_pc[i], m_valid ? m_pc : e_pc);
          check("cp0_bd", {31'd0, o_bd[i]}, {31'd0, m_valid ? m_bd : e_bd});
        end
        if (md_in[i] && md_k[i] == fc[i]) check("redirect_pc", o_rpc[i], md_tgt[i]);
        check("entry_count", ec_of(i), md_cnt[i]);
      end
      if (rst) begin
        md_in[i] = 0; md_k[i] = 0; md_tgt[i] = 0; md_cnt[i] = 0;
      end else if (!md_in[i]) begin
        if (cp0_req) begin
          md_in[i] = 1; md_k[i] = 1; md_tgt[i] = 32'h0000_4180;
          if (md_cnt[i] < cmax[i]) md_cnt[i]++;
        end else if (m_valid && m_eret) begin
          md_in[i] = 1; md_k[i] = 1; md_tgt[i] = cp0_epc;
        end
      end else if (md_k[i] == fc[i]) begin
        md_in[i] = 0;
      end else begin
        md_k[i]++;
      end
    end
  end

  task automatic idle();
    m_valid = 0; m_pc = 0; m_bd = 0; m_exc_code = 0; m_eret = 0;
    e_pc = 0; e_bd = 0; dev_int = 0; cp0_req = 0; cp0_epc = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Call right after the trigger edge with inputs idle; reports first redirect cycle.
  task automatic run_seq(output int l0, output int l1, output logic [31:0] p0,
                         output logic [31:0] p1, output int exl_seen);
    l0 = -1; l1 = -1; p0 = 'x; p1 = 'x; exl_seen = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (o_rv[0] === 1'b1 && l0 < 0) begin l0 = c; p0 = o_rpc[0]; end
      if (o_rv[1] === 1'b1 && l1 < 0) begin l1 = c; p1 = o_rpc[1]; end
      if (o_exl[0] !== 1'b0) exl_seen++;
      tick();
    end
  endtask

  int          l0, l1, xs;
  logic [31:0] p0, p1;

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    model_on = 1;
    tick();
    rst = 0;

    @(negedge clk);
    check("rst_busy", {31'd0, o_busy[0]}, 32'd0);
    check("rst_flush", {31'd0, o_flush[0]}, 32'd0);
    check("rst_rv", {31'd0, o_rv[0]}, 32'd0);
    check("rst_rpc", o_rpc[0], 32'd0);
    check("rst_ec", {16'd0, o_ec0}, 32'd0);
    tick();

    // Exception entry from a valid M instruction
    m_valid = 1; m_exc_code = 5'd10; m_pc = 32'h3008; cp0_req = 1;
    @(negedge clk);
    check("A_flush", {31'd0, o_flush[0]}, 32'd1);
    check("A_exc", {27'd0, o_exc[0]}, 32'd10);
    check("A_pc", o_pc[0], 32'h3008);
    tick(); idle();
    run_seq(l0, l1, p0, p1, xs);
    check("A_lat0", l0, 32'd2);
    check("A_lat1", l1, 32'd3);
    check("A_rpc", p0, 32'h4180);
    check("A_ec0", {16'd0, o_ec0}, 32'd1);

    // Interrupt taken on a bubble: E-stage PC/BD go to CP0
    e_pc = 32'h300C; e_bd = 1; dev_int = 6'b000001; cp0_req = 1;
    @(negedge clk);
    check("B_pc", o_pc[0], 32'h300C);
    check("B_bd", {31'd0, o_bd[0]}, 32'd1);
    check("B_hw_run", {26'd0, o_hw[0]}, 32'd1);
    tick(); cp0_req = 0;
    @(negedge clk);
    check("B_hw_flush0", {26'd0, o_hw[0]}, 32'd0);
    check("B_hw_flush1", {26'd0, o_hw[1]}, 32'd0);
    tick(); tick();
    @(negedge clk);
    check("B_hw_back", {26'd0, o_hw[0]}, 32'd1);
    idle(); tick(); tick(); tick();

    // ERET returns to EPC with a single EXLClr pulse
    m_valid = 1; m_eret = 1; cp0_epc = 32'h3010;
    @(negedge clk);
    check("C_exl", {31'd0, o_exl[0]}, 32'd1);
    tick(); idle();
    run_seq(l0, l1, p0, p1, xs);
    check("C_exl_after", xs, 32'd0);
    check("C_rpc", p0, 32'h3010);
    check("C_rpc1", p1, 32'h3010);

    // Req beats ERET in the same cycle
    m_valid = 1; m_eret = 1; cp0_epc = 32'h3010; cp0_req = 1;
    @(negedge clk);
    check("D_exl", {31'd0, o_exl[0]}, 32'd0);
    tick(); idle();
    run_seq(l0, l1, p0, p1, xs);
    check("D_rpc", p0, 32'h4180);
    check("D_lat0", l0, 32'd2);

    // Fourth entry: narrow counter saturates at 3
    cp0_req = 1;
    tick(); idle();
    run_seq(l0, l1, p0, p1, xs);
    check("E_ec0", {16'd0, o_ec0}, 32'd4);
    check("E_ec1_sat", {30'd0, o_ec1}, 32'd3);

    // Reset in FLUSH kills the sequence
    cp0_req = 1;
    tick(); idle(); rst = 1;
    @(negedge clk);
    check("F_busy_pre", {31'd0, o_busy[0]}, 32'd1);
    tick(); rst = 0;
    @(negedge clk);
    check("F_busy", {31'd0, o_busy[0]}, 32'd0);
    check("F_flush", {31'd0, o_flush[0]}, 32'd0);
    check("F_ec", {16'd0, o_ec0}, 32'd0);
    tick();
    run_seq(l0, l1, p0, p1, xs);
    check("F_no_rv0", l0, 32'hFFFF_FFFF);
    check("F_no_rv1", l1, 32'hFFFF_FFFF);

    // Randomized traffic, checked by the model every cycle
    repeat (3000) begin
      m_valid    = ($urandom_range(0, 3) != 0);
      m_pc       = $urandom & 32'hFFFF_FFFC;
      m_bd       = $urandom_range(0, 1) == 1;
      m_exc_code = 5'($urandom_range(0, 31));
      m_eret     = ($urandom_range(0, 7) == 0);
      e_pc       = $urandom & 32'hFFFF_FFFC;
      e_bd       = $urandom_range(0, 1) == 1;
      dev_int    = 6'($urandom_range(0, 63));
      cp0_req    = ($urandom_range(0, 5) == 0);
      cp0_epc    = $urandom & 32'hFFFF_FFFC;
      rst        = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle(); rst = 0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
